parking_time_tracker: RTL and testbench

- Upstream feeder of the parking-lot duration subtractor.
- Keeps a free-running 8-bit parking clock and a table of SLOTS entry timestamps.
- Allocates a slot on car entry and releases it on car exit.
- On each exit, presents the {time_in, time_out} pair, with a valid/ready handshake, to the stage that computes time_total = time_out - time_in (mod 256).

---
 rtl/parking_time_tracker_if.sv | 34 +++
 rtl/parking_time_tracker.sv | 154 +++++++++++++++
 tb/tb_parking_time_tracker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/parking_time_tracker_if.sv
// Request/response bundle between the parking lot front-end and parking_time_tracker.
// master = requester/consumer side, slave = tracker side.
interface parking_time_tracker_if #(
    parameter int SLOT_W = 3
);
    logic              car_enter;
    logic              enter_ack;
    logic              enter_reject;
    logic [SLOT_W-1:0] enter_slot;
    logic              car_exit;
    logic [SLOT_W-1:0] exit_slot;
    logic              exit_ready;
    logic              exit_err;
    logic [7:0]        time_in;
    logic [7:0]        time_out;
    logic              pair_valid;
    logic              pair_ready;
    logic              pair_ovf;
    logic [SLOT_W:0]   occupancy;
    logic              full;
    logic [7:0]        time_now;

    modport master (
        output car_enter, car_exit, exit_slot, pair_ready,
        input  enter_ack, enter_reject, enter_slot, exit_ready, exit_err,
               time_in, time_out, pair_valid, pair_ovf, occupancy, full, time_now
    );

    modport slave (
        input  car_enter, car_exit, exit_slot, pair_ready,
        output enter_ack, enter_reject, enter_slot, exit_ready, exit_err,
               time_in, time_out, pair_valid, pair_ovf, occupancy, full, time_now
    );
endinterface

// File: rtl/parking_time_tracker.sv
// Parking clock, slot allocation table and {time_in, time_out} pair producer.
// Optional stay-overflow flag per slot enabled by defining PT_OVERFLOW_DETECT_EN.
module parking_time_tracker #(
    parameter int SLOTS    = 8,
    parameter int SLOT_W   = 3,
    parameter int TICK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    parking_time_tracker_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]     presc_reg;
    logic [7:0]        time_now_reg;
    logic              tick;
    logic [SLOT_W:0]   occupancy_reg;
    logic              full;
    logic              enter_ack_reg, enter_reject_reg, exit_err_reg;
    logic [SLOT_W-1:0] enter_slot_reg;
    logic              pair_valid_reg;
    logic [7:0]        time_in_reg, time_out_reg;

    logic [SLOTS-1:0]  occ_vec, alloc_vec, free_vec;
    logic [7:0]        ts_arr [SLOTS];
    logic [SLOT_W-1:0] alloc_idx;
    logic              enter_fire, exit_ready, exit_fire, exit_in_range, exit_hit, exit_ok;

    assign tick = (presc_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg    <= '0;
            time_now_reg <= '0;
        end else if (tick) begin
            presc_reg    <= '0;
            time_now_reg <= time_now_reg + 8'd1;
        end else begin
            presc_reg    <= presc_reg + PW'(1);
        end
    end

    // Lowest-index free slot, taken from the mask before any same-cycle exit.
    always_comb begin
        alloc_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ_vec[i]) alloc_idx = SLOT_W'(i);
        end
    end

    assign full          = (occupancy_reg == (SLOT_W+1)'(SLOTS));
    assign enter_fire    = bus.car_enter && !full;
    assign exit_ready    = !pair_valid_reg || bus.pair_ready;
    assign exit_fire     = bus.car_exit && exit_ready;
    assign exit_in_range = ({1'b0, bus.exit_slot} < (SLOT_W+1)'(SLOTS));
    assign exit_hit      = exit_in_range && occ_vec[bus.exit_slot];
    assign exit_ok       = exit_fire && exit_hit;

`ifdef PT_OVERFLOW_DETECT_EN
    logic [SLOTS-1:0] wrap_vec;
    logic [7:0]       time_now_inc;
    logic             pair_ovf_reg;
    assign time_now_inc = time_now_reg + 8'd1;
`endif

    genvar gi;
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic       occ_q;
        logic [7:0] ts_q;

        assign alloc_vec[gi] = enter_fire && (alloc_idx == SLOT_W'(gi));
        assign free_vec[gi]  = exit_ok && (bus.exit_slot == SLOT_W'(gi));
        assign occ_vec[gi]   = occ_q;
        assign ts_arr[gi]    = ts_q;

        always_ff @(posedge clk) begin
            if (reset)              occ_q <= 1'b0;
            else if (alloc_vec[gi]) occ_q <= 1'b1;
            else if (free_vec[gi])  occ_q <= 1'b0;
        end

        always_ff @(posedge clk) begin
            if (alloc_vec[gi]) ts_q <= time_now_reg;
        end

`ifdef PT_OVERFLOW_DETECT_EN
        // Clock coming round to the entry stamp again means a full 256-unit lap.
        logic wrap_q;
        assign wrap_vec[gi] = wrap_q;
        always_ff @(posedge clk) begin
            if (reset)                                        wrap_q <= 1'b0;
            else if (alloc_vec[gi])                           wrap_q <= 1'b0;
            else if (tick && occ_q && (time_now_inc == ts_q)) wrap_q <= 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enter_ack_reg    <= 1'b0;
            enter_reject_reg <= 1'b0;
            enter_slot_reg   <= '0;
            exit_err_reg     <= 1'b0;
            occupancy_reg    <= '0;
        end else begin
            enter_ack_reg    <= enter_fire;
            enter_reject_reg <= bus.car_enter && full;
            exit_err_reg     <= exit_fire && !exit_hit;
            if (enter_fire) enter_slot_reg <= alloc_idx;
            case ({enter_fire, exit_ok})
                2'b10:   occupancy_reg <= occupancy_reg + (SLOT_W+1)'(1);
                2'b01:   occupancy_reg <= occupancy_reg - (SLOT_W+1)'(1);
                default: occupancy_reg <= occupancy_reg;
            endcase
        end
    end

    // Pair register: a new exit overwrites a pair being consumed this cycle, so no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            pair_valid_reg <= 1'b0;
            time_in_reg    <= '0;
            time_out_reg   <= '0;
        end else if (exit_ok) begin
            pair_valid_reg <= 1'b1;
            time_in_reg    <= ts_arr[bus.exit_slot];
            time_out_reg   <= time_now_reg;
        end else if (bus.pair_ready) begin
            pair_valid_reg <= 1'b0;
        end
    end

`ifdef PT_OVERFLOW_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset)        pair_ovf_reg <= 1'b0;
        else if (exit_ok) pair_ovf_reg <= wrap_vec[bus.exit_slot];
    end
    assign bus.pair_ovf = pair_ovf_reg;
`else
    assign bus.pair_ovf = 1'b0;
`endif

    assign bus.enter_ack    = enter_ack_reg;
    assign bus.enter_reject = enter_reject_reg;
    assign bus.enter_slot   = enter_slot_reg;
    assign bus.exit_ready   = exit_ready;
    assign bus.exit_err     = exit_err_reg;
    assign bus.time_in      = time_in_reg;
    assign bus.time_out     = time_out_reg;
    assign bus.pair_valid   = pair_valid_reg;
    assign bus.occupancy    = occupancy_reg;
    assign bus.full         = full;
    assign bus.time_now     = time_now_reg;
endmodule

// File: tb/tb_parking_time_tracker.sv
// Scoreboard bench for parking_time_tracker: directed scenarios followed by random traffic,
// checked against an absolute-time model of the lot.
`timescale 1ns/1ps
module tb_parking_time_tracker;
    localparam int SLOTS    = 8;
    localparam int SLOT_W   = 4;
    localparam int TICK_DIV = 4;
`ifdef PT_OVERFLOW_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parking_time_tracker_if #(.SLOT_W(SLOT_W)) bus ();

    parking_time_tracker #(
        .SLOTS(SLOTS), .SLOT_W(SLOT_W), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        bit ack; bit rej; int slot; bit err; bit pv; int occ; bit full; int tnow;
    } stat_t;
    typedef struct { int tin; int tout; bit ovf; } pair_t;

    stat_t stat_q[$];
    pair_t pair_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Model: occupancy by slot, entry time in absolute (unwrapped) units, cycles since reset.
    bit m_occ [SLOTS];
    int m_abs_in [SLOTS];
    int m_cyc = 0;
    bit m_pend = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int occ_count();
        int c = 0;
        for (int i = 0; i < SLOTS; i++) c += int'(m_occ[i]);
        return c;
    endfunction

    // Drive one cycle of inputs, predict the outcome of the coming edge, then advance.
    task automatic cycle(input bit rst, input bit en, input bit ex, input int es, input bit pr_in);
        stat_t s;
        pair_t p;
        int    now_abs;
        bit    pr, acc, ok, found;
        pr = rst ? 1'b0 : pr_in;
        reset          = rst;
        bus.car_enter  = en;
        bus.car_exit   = ex;
        bus.exit_slot  = SLOT_W'(es);
        bus.pair_ready = pr;
        s = '{ack:0, rej:0, slot:0, err:0, pv:0, occ:0, full:0, tnow:0};
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) m_occ[i] = 1'b0;
            m_cyc  = 0;
            m_pend = 1'b0;
            pair_q.delete();
        end else begin
            now_abs = m_cyc / TICK_DIV;
            acc = ex && (!m_pend || pr);
            ok  = acc && (es < SLOTS) && m_occ[es];
            if (en && occ_count() == SLOTS) begin
                s.rej = 1'b1;
            end else if (en) begin
                found = 1'b0;
                for (int i = 0; i < SLOTS; i++) begin
                    if (!found && !m_occ[i]) begin
                        found = 1'b1;
                        s.ack = 1'b1;
                        s.slot = i;
                    end
                end
            end
            if (ok) begin
                p.tin  = m_abs_in[es] % 256;
                p.tout = now_abs % 256;
                p.ovf  = OVF_EN && (now_abs - m_abs_in[es] >= 256);
                pair_q.push_back(p);
                m_occ[es] = 1'b0;
            end
            if (s.ack) begin
                m_occ[s.slot]    = 1'b1;
                m_abs_in[s.slot] = now_abs;
            end
            s.err  = acc && !ok;
            m_pend = ok ? 1'b1 : (pr ? 1'b0 : m_pend);
            m_cyc++;
        end
        s.pv   = m_pend;
        s.occ  = occ_count();
        s.full = (s.occ == SLOTS);
        s.tnow = (m_cyc / TICK_DIV) % 256;
        stat_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle status plus pair consumption on each handshake.
    initial begin : monitor
        stat_t s;
        pair_t p;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("time_now", int'(bus.time_now), s.tnow);
                check("occupancy", int'(bus.occupancy), s.occ);
                check("full", int'(bus.full), int'(s.full));
                check("enter_ack", int'(bus.enter_ack), int'(s.ack));
                check("enter_reject", int'(bus.enter_reject), int'(s.rej));
                if (s.ack) check("enter_slot", int'(bus.enter_slot), s.slot);
                check("exit_err", int'(bus.exit_err), int'(s.err));
                check("pair_valid", int'(bus.pair_valid), int'(s.pv));
                check("exit_ready", int'(bus.exit_ready), int'(!s.pv || bus.pair_ready));
            end
            if (bus.pair_valid === 1'b1 && bus.pair_ready === 1'b1) begin
                if (pair_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pair_unexpected: got pair %0d/%0d expected none at %0t",
                             bus.time_in, bus.time_out, $time);
                end else begin
                    p = pair_q.pop_front();
                    check("time_in", int'(bus.time_in), p.tin);
                    check("time_out", int'(bus.time_out), p.tout);
                    check("pair_ovf", int'(bus.pair_ovf), int'(p.ovf));
                    $display("pair: time_in=%0d time_out=%0d ovf=%0d", bus.time_in, bus.time_out, bus.pair_ovf);
                end
            end
        end
    end

    initial begin : stimulus
        bit en, ex, pr, rst;
        int es;
        reset = 1'b1;
        bus.car_enter = 1'b0;
        bus.car_exit = 1'b0;
        bus.exit_slot = '0;
        bus.pair_ready = 1'b0;

        repeat (3) cycle(1, 0, 0, 0, 0);
        // Enter at time 3, exit at time 8, then idle up to 40 cycles (time 10).
        repeat (12) cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 1);
        repeat (19) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        repeat (7) cycle(0, 0, 0, 0, 1);

        // Fill the lot, reject a 9th entry, enter+exit together, then reuse slot 2.
        repeat (SLOTS) cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 1, 2, 1);
        cycle(0, 1, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 0, 1);

        // Free slot 5, then exit on it again and on an out-of-range slot.
        cycle(0, 0, 1, 5, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 5, 1);
        cycle(0, 0, 1, 9, 1);
        repeat (2) cycle(0, 0, 0, 0, 1);

        // Backpressure: second exit held while the first pair waits.
        cycle(0, 0, 1, 0, 0);
        repeat (3) cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 1);
        repeat (2) cycle(0, 0, 0, 0, 1);

        // Long stay beyond one full lap of the parking clock.
        cycle(0, 1, 0, 0, 1);
        repeat (256 * TICK_DIV + 8) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        repeat (2) cycle(0, 0, 0, 0, 1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 999) == 0);
            en  = ($urandom_range(0, 99) < 35);
            ex  = ($urandom_range(0, 99) < 35);
            es  = $urandom_range(0, 9);
            pr  = ($urandom_range(0, 99) < 70);
            cycle(rst, en, ex, es, pr);
        end

        repeat (4) cycle(0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        check("pair_drain", pair_q.size(), 0);
        check("status_drain", stat_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
